// File: rtl/tqvp_arb_pkg.sv
// Shared definitions for the TinyQV register-port arbiter: FSM state
// encoding, transaction width codes and the idle strobe value.
package tqvp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_DONE  = 2'b11
    } arb_state_e;

    // Transaction width codes, identical to the active-low strobe encoding
    // the peripheral expects on per_data_write_n / per_data_read_n.
    localparam logic [1:0] TXN_BYTE    = 2'b00;
    localparam logic [1:0] TXN_HALF    = 2'b01;
    localparam logic [1:0] TXN_WORD    = 2'b10;
    localparam logic [1:0] TXN_NONE    = 2'b11;
    localparam logic [1:0] STROBE_IDLE = 2'b11;

    // Bit mask that keeps only the lanes covered by a transaction width.
    function automatic logic [31:0] width_mask(input logic [1:0] width);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        case (width)
            TXN_BYTE: mask = 32'h0000_00FF;
            TXN_HALF: mask = 32'h0000_FFFF;
            TXN_WORD: mask = 32'hFFFF_FFFF;
            default:  mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tqvp_rdata_mask.sv
// Combinational read-data masking: clears the lanes above the transaction
// width. An illegal width yields zero.
module tqvp_rdata_mask
    import tqvp_arb_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    assign data_o = data_i & width_mask(width_i);

endmodule

// File: rtl/tqvp_reg_arbiter.sv
// Two-requester round-robin arbiter sharing one TinyQV peripheral register
// port between the SPI host (m0) and the on-chip sequencer (m1).
// Optional build macro ARB_TIMEOUT_EN adds a read wait-state timeout that
// completes the read with err=1 after TIMEOUT_CYCLES cycles without ready.
module tqvp_reg_arbiter
    import tqvp_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 6
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [1:0]        m0_width,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [1:0]        m1_width,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic [ADDR_W-1:0] per_address,
    output logic [31:0]       per_data_in,
    output logic [1:0]        per_data_write_n,
    output logic [1:0]        per_data_read_n,
    input  logic [31:0]       per_data_out,
    input  logic              per_data_ready,

    output logic              busy,
    output logic              grant_id
);

    arb_state_e        state_q, state_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic [1:0]        width_q, width_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              any_req;
    logic              req_owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_width;
    logic [31:0]       rdata_masked;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
`else
    // Keeps the timeout parameter referenced when the counter is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Grant selection: the priority pointer breaks ties, a lone requester wins.
    assign any_req   = m0_req | m1_req;
    assign req_owner = (m0_req && m1_req) ? prio_q : m1_req;
    assign sel_we    = req_owner ? m1_we    : m0_we;
    assign sel_addr  = req_owner ? m1_addr  : m0_addr;
    assign sel_wdata = req_owner ? m1_wdata : m0_wdata;
    assign sel_width = req_owner ? m1_width : m0_width;

    tqvp_rdata_mask u_rdata_mask (
        .width_i (width_q),
        .data_i  (per_data_out),
        .data_o  (rdata_masked)
    );

    // Next-state and datapath update for the IDLE/WRITE/READ/DONE sequence.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        width_d = width_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d = req_owner;
                    prio_d  = ~req_owner;
                    width_d = sel_width;
                    rdata_d = 32'h0000_0000;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_d = '0;
                    err_d      = 1'b0;
`endif
                    if (sel_width == TXN_NONE) begin
                        // Illegal width: complete without touching the peripheral.
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        state_d = sel_we ? ST_WRITE : ST_READ;
                    end
                end
            end

            ST_WRITE: begin
                state_d = ST_DONE;
            end

            ST_READ: begin
                if (per_data_ready) begin
                    rdata_d = rdata_masked;
                    state_d = ST_DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            ST_DONE: begin
                // req is deliberately not sampled here.
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            width_q <= TXN_NONE;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Read wait-state counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign m0_err = err_q;
    assign m1_err = err_q;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    // NOTE: strobes decode straight from state_q, so an asynchronous reset
    // returns them to idle immediately rather than on the next edge.
    assign per_data_write_n = (state_q == ST_WRITE) ? width_q : STROBE_IDLE;
    assign per_data_read_n  = (state_q == ST_READ)  ? width_q : STROBE_IDLE;
    assign per_address      = addr_q;
    assign per_data_in      = wdata_q;

    assign m0_ack   = (state_q == ST_DONE) && !owner_q;
    assign m1_ack   = (state_q == ST_DONE) &&  owner_q;
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = owner_q;

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Self-checking bench for tqvp_reg_arbiter: directed transactions with a
// scoreboard of expected completions checked by an ack monitor.
// Honours ARB_TIMEOUT_EN the same way the design does.
module tb_tqvp_reg_arbiter;
    import tqvp_arb_pkg::*;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned TO_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [31:0]       m0_wdata, m1_wdata;
    logic [1:0]        m0_width, m1_width;
    logic              m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0]       m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] per_address;
    logic [31:0]       per_data_in, per_data_out;
    logic [1:0]        per_data_write_n, per_data_read_n;
    logic              per_data_ready;
    logic              busy, grant_id;

    tqvp_reg_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_width(m0_width), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_width(m1_width), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .per_address(per_address), .per_data_in(per_data_in),
        .per_data_write_n(per_data_write_n), .per_data_read_n(per_data_read_n),
        .per_data_out(per_data_out), .per_data_ready(per_data_ready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Peripheral model: ready after wait_cfg read cycles, or never.
    int   wait_cfg    = 0;
    logic never_ready = 1'b0;
    int   rd_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_wait <= 0;
        else if (per_data_read_n != 2'b11 && !per_data_ready)
            rd_wait <= rd_wait + 1;
        else
            rd_wait <= 0;
    end

    assign per_data_ready = (per_data_read_n != 2'b11) && !never_ready && (rd_wait == wait_cfg);

    // Scoreboard of expected completions.
    typedef struct {
        logic        id;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        err;
        int          rd_cyc;
        int          wr_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input logic id, input logic chk, input logic [31:0] rdata,
                            input logic err, input int rd_cyc, input int wr_cyc);
        exp_t e;
        e.id = id; e.chk_rdata = chk; e.rdata = rdata; e.err = err;
        e.rd_cyc = rd_cyc; e.wr_cyc = wr_cyc;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] exp_mask(input logic [1:0] width, input logic [31:0] d);
        case (width)
            2'b00:   return {24'h0, d[7:0]};
            2'b01:   return {16'h0, d[15:0]};
            2'b10:   return d;
            default: return 32'h0;
        endcase
    endfunction

    // Ack monitor: strobe-cycle counting per transaction and scoreboard pop.
    int   rd_cnt, wr_cnt;
    logic prev_ack;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt   <= 0;
            wr_cnt   <= 0;
            prev_ack <= 1'b0;
        end else if (m0_ack || m1_ack) begin
            check("dual_ack", {31'h0, m0_ack && m1_ack}, 32'h0);
            check("ack_pulse", {31'h0, prev_ack}, 32'h0);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_id", {31'h0, m1_ack}, {31'h0, e.id});
                check("grant_id", {31'h0, grant_id}, {31'h0, e.id});
                if (e.chk_rdata)
                    check("rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
                check("err", {31'h0, e.id ? m1_err : m0_err}, {31'h0, e.err});
                check("rd_strobe_cycles", rd_cnt, e.rd_cyc);
                check("wr_strobe_cycles", wr_cnt, e.wr_cyc);
            end
            rd_cnt   <= 0;
            wr_cnt   <= 0;
            prev_ack <= 1'b1;
        end else begin
            rd_cnt   <= rd_cnt + ((per_data_read_n != 2'b11) ? 1 : 0);
            wr_cnt   <= wr_cnt + ((per_data_write_n != 2'b11) ? 1 : 0);
            prev_ack <= 1'b0;
        end
    end

    task automatic set_master(input logic id, input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] wdata, input logic [1:0] width);
        if (!id) begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_width = width;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_width = width;
        end
    endtask

    // One directed transaction from IDLE; exp_lat counts edges from the edge
    // that samples req to the cycle in which ack is visible.
    task automatic do_txn(input string tag, input logic id, input logic we,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                          input logic [1:0] width, input int waits, input logic never,
                          input logic [31:0] pdata, input int exp_lat, input logic err_exp);
        int lat;
        int rd_c, wr_c;
        logic [31:0] rd_exp;
        @(negedge clk);
        wait_cfg     = waits;
        never_ready  = never;
        per_data_out = pdata;
        rd_exp = err_exp ? 32'h0 : exp_mask(width, pdata);
        rd_c = 0; wr_c = 0;
        if (width != TXN_NONE) begin
            if (we) wr_c = 1;
            else    rd_c = exp_lat - 1;
        end
        push_exp(id, !we || width == TXN_NONE, rd_exp, err_exp, rd_c, wr_c);
        set_master(id, we, addr, wdata, width);
        if (!id) m0_req = 1'b1; else m1_req = 1'b1;
        lat = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1 && width != TXN_NONE) begin
                if (we) begin
                    check({tag, "_write_n"}, {30'h0, per_data_write_n}, {30'h0, width});
                    check({tag, "_address"}, {26'h0, per_address}, {26'h0, addr});
                    check({tag, "_data_in"}, per_data_in, wdata);
                end else begin
                    check({tag, "_read_n"}, {30'h0, per_data_read_n}, {30'h0, width});
                end
            end
            if (m0_ack || m1_ack) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        m0_req = 1'b0;
        m1_req = 1'b0;
        never_ready = 1'b0;
    endtask

    task automatic wait_ack_count(input string tag, input int want, input int budget);
        int seen;
        seen = 0;
        for (int n = 0; n < budget && seen < want; n++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) seen++;
        end
        check({tag, "_ack_count"}, seen, want);
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        set_master(1'b0, 1'b0, '0, 32'h0, TXN_WORD);
        set_master(1'b1, 1'b0, '0, 32'h0, TXN_WORD);
        per_data_out = 32'h0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_write_n", {30'h0, per_data_write_n}, 32'h3);
        check("rst_read_n", {30'h0, per_data_read_n}, 32'h3);
        check("rst_address", {26'h0, per_address}, 32'h0);
        check("rst_data_in", per_data_in, 32'h0);
        check("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        check("rst_err", {30'h0, m1_err, m0_err}, 32'h0);
        check("rst_busy_grant", {30'h0, busy, grant_id}, 32'h0);
        rst_n = 1'b1;

        // Fairness from reset: both request continuously, m0 first, strict alternation.
        @(negedge clk);
        set_master(1'b0, 1'b1, 6'h01, 32'h1111_1111, TXN_WORD);
        set_master(1'b1, 1'b1, 6'h02, 32'h2222_2222, TXN_WORD);
        for (int i = 0; i < 4; i++) push_exp(i[0], 1'b0, 32'h0, 1'b0, 0, 1);
        m0_req = 1'b1; m1_req = 1'b1;
        wait_ack_count("fair", 4, 100);

        do_txn("wr_word", 1'b0, 1'b1, 6'h05, 32'h1234_5678, TXN_WORD, 0, 1'b0, 32'h0, 2, 1'b0);
        do_txn("rd_byte", 1'b1, 1'b0, 6'h3F, 32'h0, TXN_BYTE, 3, 1'b0, 32'hAABB_CCDD, 5, 1'b0);
        do_txn("rd_half", 1'b0, 1'b0, 6'h10, 32'h0, TXN_HALF, 0, 1'b0, 32'hAABB_CCDD, 2, 1'b0);
        do_txn("rd_word", 1'b1, 1'b0, 6'h2A, 32'h0, TXN_WORD, 1, 1'b0, 32'hDEAD_BEEF, 3, 1'b0);
        do_txn("illegal", 1'b0, 1'b0, 6'h01, 32'h0, TXN_NONE, 0, 1'b0, 32'hFFFF_FFFF, 1, 1'b0);
        do_txn("wr_byte", 1'b1, 1'b1, 6'h3F, 32'hCAFE_F00D, TXN_BYTE, 0, 1'b0, 32'h0, 2, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Ready never arrives: error completion after TIMEOUT_CYCLES read cycles.
        do_txn("timeout", 1'b0, 1'b0, 6'h07, 32'h0, TXN_BYTE, 0, 1'b1, 32'h5555_5555,
               1 + TO_CYC, 1'b1);
`else
        // Without the timeout the read waits indefinitely; recover with reset.
        @(negedge clk);
        never_ready = 1'b1;
        set_master(1'b0, 1'b0, 6'h07, 32'h0, TXN_BYTE);
        m0_req = 1'b1;
        repeat (20) @(negedge clk);
        check("no_to_busy", {31'h0, busy}, 32'h1);
        check("no_to_read_n", {30'h0, per_data_read_n}, {30'h0, TXN_BYTE});
        m0_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("no_to_rst_read_n", {30'h0, per_data_read_n}, 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        never_ready = 1'b0;
`endif

        // Reset during a read wait: strobes drop immediately, no ack.
        @(negedge clk);
        never_ready = 1'b1;
        set_master(1'b1, 1'b0, 6'h22, 32'h0, TXN_HALF);
        m1_req = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_read_n", {30'h0, per_data_read_n}, {30'h0, TXN_HALF});
        rst_n = 1'b0;
        #1;
        check("mid_rst_read_n", {30'h0, per_data_read_n}, 32'h3);
        check("mid_rst_write_n", {30'h0, per_data_write_n}, 32'h3);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_ack", {30'h0, m1_ack, m0_ack}, 32'h0);
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        never_ready = 1'b0;

        // Simultaneous request after reset: m0 wins.
        @(negedge clk);
        set_master(1'b0, 1'b1, 6'h11, 32'hA5A5_0F0F, TXN_WORD);
        set_master(1'b1, 1'b1, 6'h12, 32'h5A5A_F0F0, TXN_WORD);
        push_exp(1'b0, 1'b0, 32'h0, 1'b0, 0, 1);
        m0_req = 1'b1; m1_req = 1'b1;
        wait_ack_count("post_rst", 1, 20);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
